imm_stage_buf: RTL and testbench

Registered, parametrised immediate-generation stage for the RISC-V pipeline decode path. It takes the instruction bits above the opcode plus a 3-bit immediate type. It produces the sign- or zero-extended XLEN-wide immediate one cycle later, behind a 2-entry skid buffer with valid/ready handshakes on both sides. It also adds a CSR zero-extended immediate type, a side-band tag, flush, and an illegal-type flag and counter.

---
 rtl/imm_stage_buf.sv | 160 ++++++++++++++++
 tb/tb_imm_stage_buf.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_stage_buf.sv
// RISC-V decode immediate generator, registered behind a two-entry skid buffer.
// Carries a side-band tag, supports flush, and counts reserved-type entries.
module imm_stage_buf #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             CPU_CLK,
   input  logic             CPU_RST_N,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      in_instr,
   input  logic [2:0]       in_type,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal,
   output logic [15:0]      illegal_cnt
);

   localparam logic [2:0] TY_I   = 3'd1;
   localparam logic [2:0] TY_S   = 3'd2;
   localparam logic [2:0] TY_B   = 3'd3;
   localparam logic [2:0] TY_U   = 3'd4;
   localparam logic [2:0] TY_J   = 3'd5;
   localparam logic [2:0] TY_Z   = 3'd6;
   localparam logic [2:0] TY_ILL = 3'd7;

   // Fill state is {skid valid, main valid}
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b01;
   localparam logic [1:0] ST_FULL  = 2'b11;

   logic             r_mainValid;
   logic             r_skidValid;
   logic             r_inReady;
   logic [XLEN-1:0]  r_mainImm;
   logic [TAG_W-1:0] r_mainTag;
   logic             r_mainIll;
   logic [XLEN-1:0]  r_skidImm;
   logic [TAG_W-1:0] r_skidTag;
   logic             r_skidIll;
   logic [15:0]      r_illCnt;

   logic             w_b31;
   logic [31:0]      w_imm32;
   logic [XLEN-1:0]  w_imm;
   logic             w_illegal;
   logic             w_accept;
   logic             w_consume;
   logic [1:0]       w_state;

   // in_instr[k] holds instruction bit k+7
   assign w_b31 = in_instr[24];

   always_comb begin
      w_imm32   = 32'd0;
      w_illegal = 1'b0;
      case (in_type)
         TY_I:    w_imm32 = {{20{w_b31}}, in_instr[24:13]};
         TY_S:    w_imm32 = {{20{w_b31}}, in_instr[24:18], in_instr[4:0]};
         TY_B:    w_imm32 = {{20{w_b31}}, in_instr[0], in_instr[23:18], in_instr[4:1], 1'b0};
         TY_U:    w_imm32 = {in_instr[24:5], 12'd0};
         TY_J:    w_imm32 = {{12{w_b31}}, in_instr[12:5], in_instr[13], in_instr[23:14], 1'b0};
         TY_Z:    w_imm32 = {27'd0, in_instr[12:8]};
         TY_ILL:  w_illegal = 1'b1;
         default: w_imm32 = 32'd0;
      endcase
   end

   // Bit 31 of every 32-bit form is already the correct extension bit
   generate
      if (XLEN == 64) begin : g_x64
         assign w_imm = {{32{w_imm32[31]}}, w_imm32};
      end else begin : g_x32
         assign w_imm = w_imm32;
      end
   endgenerate

   assign w_accept  = in_valid & r_inReady & ~flush;
   assign w_consume = r_mainValid & out_ready;
   assign w_state   = {r_skidValid, r_mainValid};

   always_ff @(posedge CPU_CLK) begin
      if (!CPU_RST_N) begin
         r_mainValid <= 1'b0;
         r_skidValid <= 1'b0;
         r_inReady   <= 1'b1;
         r_mainImm   <= '0;
         r_mainTag   <= '0;
         r_mainIll   <= 1'b0;
         r_skidImm   <= '0;
         r_skidTag   <= '0;
         r_skidIll   <= 1'b0;
      end else if (flush) begin
         r_mainValid <= 1'b0;
         r_skidValid <= 1'b0;
         r_inReady   <= 1'b1;
      end else begin
         case (w_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_mainValid <= 1'b1;
                  r_mainImm   <= w_imm;
                  r_mainTag   <= in_tag;
                  r_mainIll   <= w_illegal;
               end
            end
            ST_ONE: begin
               if (w_accept && w_consume) begin
                  r_mainImm <= w_imm;
                  r_mainTag <= in_tag;
                  r_mainIll <= w_illegal;
               end else if (w_accept) begin
                  r_skidValid <= 1'b1;
                  r_inReady   <= 1'b0;
                  r_skidImm   <= w_imm;
                  r_skidTag   <= in_tag;
                  r_skidIll   <= w_illegal;
               end else if (w_consume) begin
                  r_mainValid <= 1'b0;
               end
            end
            ST_FULL: begin
               if (w_consume) begin
                  r_skidValid <= 1'b0;
                  r_inReady   <= 1'b1;
                  r_mainImm   <= r_skidImm;
                  r_mainTag   <= r_skidTag;
                  r_mainIll   <= r_skidIll;
               end
            end
            default: begin
               r_mainValid <= 1'b0;
               r_skidValid <= 1'b0;
               r_inReady   <= 1'b1;
            end
         endcase
      end
   end

   // Survives flush on purpose; only reset clears it
   always_ff @(posedge CPU_CLK) begin
      if (!CPU_RST_N) begin
         r_illCnt <= 16'd0;
      end else if (w_accept && w_illegal && (r_illCnt != 16'hFFFF)) begin
         r_illCnt <= r_illCnt + 16'd1;
      end
   end

   assign in_ready    = r_inReady;
   assign out_valid   = r_mainValid;
   assign out_imm     = r_mainImm;
   assign out_tag     = r_mainTag;
   assign out_illegal = r_mainIll;
   assign illegal_cnt = r_illCnt;

endmodule

// File: tb/tb_imm_stage_buf.sv
// Scoreboard bench for imm_stage_buf: 32- and 64-bit instances share one stimulus
// stream, expectations come from an arithmetic immediate model and a queue.
module tb_imm_stage_buf;

   typedef struct {
      logic [31:0] imm32;
      logic [63:0] imm64;
      logic [4:0]  tag;
      logic        ill;
   } exp_t;

   logic        CPU_CLK = 1'b0;
   logic        CPU_RST_N;
   logic        in_valid;
   logic [24:0] in_instr;
   logic [2:0]  in_type;
   logic [4:0]  in_tag;
   logic        flush;
   logic        out_ready;

   logic        inReady32, outValid32, outIll32;
   logic [31:0] outImm32;
   logic [4:0]  outTag32;
   logic [15:0] illCnt32;
   logic        inReady64, outValid64, outIll64;
   logic [63:0] outImm64;
   logic [4:0]  outTag64;
   logic [15:0] illCnt64;

   exp_t        q[$];
   logic [15:0] modelCnt = 16'd0;
   int          checks = 0;
   int          errors = 0;

   imm_stage_buf #(.XLEN(32), .TAG_W(5)) u_dut32 (
      .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N), .in_valid(in_valid), .in_ready(inReady32),
      .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag), .flush(flush),
      .out_valid(outValid32), .out_ready(out_ready), .out_imm(outImm32), .out_tag(outTag32),
      .out_illegal(outIll32), .illegal_cnt(illCnt32));

   imm_stage_buf #(.XLEN(64), .TAG_W(5)) u_dut64 (
      .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N), .in_valid(in_valid), .in_ready(inReady64),
      .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag), .flush(flush),
      .out_valid(outValid64), .out_ready(out_ready), .out_imm(outImm64), .out_tag(outTag64),
      .out_illegal(outIll64), .illegal_cnt(illCnt64));

   always #5 CPU_CLK = ~CPU_CLK;

   function automatic longint sx(input longint val, input int bits);
      return (val >= (longint'(1) << (bits - 1))) ? val - (longint'(1) << bits) : val;
   endfunction

   // Immediate value as an integer, taken straight from the RISC-V field layout
   function automatic logic [63:0] refImm(input logic [31:0] ins, input int ty);
      longint w = longint'(ins);
      longint v;
      case (ty)
         1: v = sx((w >> 20) & 'hFFF, 12);
         2: v = sx((((w >> 25) & 'h7F) << 5) | ((w >> 7) & 'h1F), 12);
         3: v = sx((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 'h3F) << 5) | (((w >> 8) & 'hF) << 1), 13);
         4: v = sx(w & 'hFFFFF000, 32);
         5: v = sx((((w >> 31) & 1) << 20) | (((w >> 12) & 'hFF) << 12) | (((w >> 20) & 1) << 11) | (((w >> 21) & 'h3FF) << 1), 21);
         6: v = (w >> 15) & 'h1F;
         default: v = 0;
      endcase
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle, then account for what the edge did in the model
   task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [2:0] ty,
                                input logic [4:0] tg, input logic ordy, input logic fl);
      logic readyNow;
      exp_t e;
      readyNow  = (q.size() < 2);
      in_valid  = v;
      in_instr  = ins[31:7];
      in_type   = ty;
      in_tag    = tg;
      out_ready = ordy;
      flush     = fl;
      @(posedge CPU_CLK);
      if (!CPU_RST_N) begin
         q.delete();
         modelCnt = 16'd0;
      end else if (fl) begin
         q.delete();
      end else if (v && readyNow) begin
         e.imm64 = refImm(ins, int'(ty));
         e.imm32 = e.imm64[31:0];
         e.tag   = tg;
         e.ill   = (ty == 3'd7);
         q.push_back(e);
         if (e.ill && modelCnt != 16'hFFFF) modelCnt = modelCnt + 16'd1;
      end
      #1;
   endtask

   always @(negedge CPU_CLK) begin
      exp_t e;
      checkOutput("in_ready", {63'd0, inReady32}, {63'd0, q.size() < 2});
      checkOutput("out_valid", {63'd0, outValid32}, {63'd0, q.size() > 0});
      checkOutput("out_valid64", {63'd0, outValid64}, {63'd0, q.size() > 0});
      checkOutput("illegal_cnt", {48'd0, illCnt32}, {48'd0, modelCnt});
      if (outValid32 && q.size() > 0) begin
         e = q[0];
         checkOutput("out_imm32", {32'd0, outImm32}, {32'd0, e.imm32});
         checkOutput("out_imm64", outImm64, e.imm64);
         checkOutput("out_tag", {59'd0, outTag32}, {59'd0, e.tag});
         checkOutput("out_illegal", {63'd0, outIll32}, {63'd0, e.ill});
         if (out_ready) void'(q.pop_front());
      end
   end

   initial begin
      int guard;
      CPU_RST_N = 1'b0;
      in_valid = 1'b0; in_instr = '0; in_type = '0; in_tag = '0; flush = 1'b0; out_ready = 1'b0;

      applyStimulus(1'b1, 32'hFFF00093, 3'd1, 5'd7, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("rst_out_valid", {63'd0, outValid32}, 64'd0);
      checkOutput("rst_out_imm", outImm64, 64'd0);
      checkOutput("rst_out_tag", {59'd0, outTag32}, 64'd0);
      checkOutput("rst_out_illegal", {63'd0, outIll32}, 64'd0);
      checkOutput("rst_illegal_cnt", {48'd0, illCnt32}, 64'd0);
      checkOutput("rst_in_ready", {63'd0, inReady32}, 64'd1);
      CPU_RST_N = 1'b1;
      applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

      applyStimulus(1'b1, 32'hFFF00093, 3'd1, 5'd3, 1'b1, 1'b0);
      checkOutput("itype_valid", {63'd0, outValid32}, 64'd1);
      checkOutput("itype_imm", {32'd0, outImm32}, 64'hFFFFFFFF);
      checkOutput("itype_tag", {59'd0, outTag32}, 64'd3);
      applyStimulus(1'b1, 32'hFE000EE3, 3'd3, 5'd4, 1'b1, 1'b0);
      checkOutput("btype_imm", {32'd0, outImm32}, 64'hFFFFFFFC);
      applyStimulus(1'b1, 32'h0010006F, 3'd5, 5'd5, 1'b1, 1'b0);
      checkOutput("jtype_imm", {32'd0, outImm32}, 64'h00000800);
      applyStimulus(1'b1, 32'h00112423, 3'd2, 5'd6, 1'b1, 1'b0);
      checkOutput("stype_imm", {32'd0, outImm32}, 64'h00000008);
      applyStimulus(1'b1, 32'h800002B7, 3'd4, 5'd7, 1'b1, 1'b0);
      checkOutput("utype_imm64", outImm64, 64'hFFFFFFFF80000000);
      checkOutput("utype_imm32", {32'd0, outImm32}, 64'h80000000);
      applyStimulus(1'b1, 32'h3401D073, 3'd6, 5'd8, 1'b1, 1'b0);
      checkOutput("ztype_imm64", outImm64, 64'h3);
      applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

      applyStimulus(1'b1, $urandom, 3'd1, 5'd1, 1'b0, 1'b0);
      checkOutput("bp_ready_after1", {63'd0, inReady32}, 64'd1);
      applyStimulus(1'b1, $urandom, 3'd1, 5'd2, 1'b0, 1'b0);
      checkOutput("bp_ready_after2", {63'd0, inReady32}, 64'd0);
      checkOutput("bp_head_tag", {59'd0, outTag32}, 64'd1);
      applyStimulus(1'b1, 32'h00500093, 3'd1, 5'd3, 1'b0, 1'b0);
      checkOutput("bp_stall_ready", {63'd0, inReady32}, 64'd0);
      applyStimulus(1'b1, 32'h00500093, 3'd1, 5'd3, 1'b1, 1'b0);
      checkOutput("bp_drain_tag2", {59'd0, outTag32}, 64'd2);
      checkOutput("bp_ready_rise", {63'd0, inReady32}, 64'd1);
      applyStimulus(1'b1, 32'h00500093, 3'd1, 5'd3, 1'b1, 1'b0);
      checkOutput("bp_tag3", {59'd0, outTag32}, 64'd3);
      checkOutput("bp_tag3_valid", {63'd0, outValid32}, 64'd1);
      applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);
      checkOutput("bp_empty", {63'd0, outValid32}, 64'd0);

      applyStimulus(1'b1, $urandom, 3'd2, 5'd4, 1'b0, 1'b0);
      applyStimulus(1'b1, $urandom, 3'd3, 5'd5, 1'b0, 1'b0);
      applyStimulus(1'b1, $urandom, 3'd1, 5'd9, 1'b0, 1'b1);
      checkOutput("flush_valid", {63'd0, outValid32}, 64'd0);
      checkOutput("flush_ready", {63'd0, inReady32}, 64'd1);
      applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);
      checkOutput("flush_nothing_later", {63'd0, outValid32}, 64'd0);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, $urandom, 3'd7, 5'(10 + i), 1'b1, 1'b0);
         checkOutput("ill_flag", {63'd0, outIll32}, 64'd1);
         checkOutput("ill_imm", outImm64, 64'd0);
      end
      checkOutput("ill_cnt3", {48'd0, illCnt32}, 64'd3);
      applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                       5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0,
                       $urandom_range(0, 31) == 0);
      end

      guard = 0;
      while (modelCnt != 16'hFFFF && guard < 70000) begin
         applyStimulus(1'b1, $urandom, 3'd7, 5'($urandom_range(0, 31)), 1'b1, 1'b0);
         guard++;
      end
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom, 3'd7, 5'd1, 1'b1, 1'b0);
      checkOutput("cnt_saturate", {48'd0, illCnt32}, 64'hFFFF);
      checkOutput("cnt_saturate64", {48'd0, illCnt64}, 64'hFFFF);

      applyStimulus(1'b1, $urandom, 3'd7, 5'd2, 1'b0, 1'b0);
      CPU_RST_N = 1'b0;
      applyStimulus(1'b1, $urandom, 3'd7, 5'd3, 1'b0, 1'b0);
      checkOutput("rst2_cnt", {48'd0, illCnt32}, 64'd0);
      checkOutput("rst2_valid", {63'd0, outValid32}, 64'd0);
      checkOutput("rst2_ready", {63'd0, inReady32}, 64'd1);
      checkOutput("rst2_imm", outImm64, 64'd0);
      checkOutput("rst2_illegal", {63'd0, outIll64}, 64'd0);
      CPU_RST_N = 1'b1;
      applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
